// File: rtl/pcie_us_rq_tag_mgr.sv
// ---------------------------------------------------------------------------
// pcie_us_rq_tag_mgr
//
// Requester tag allocator for the UltraScale/UltraScale+ PCIe RQ interface.
// A free tag is offered on m_tag/m_tag_valid. The requester takes it with
// m_tag_ready. The tag is returned on s_release_tag/s_release_valid when the
// final completion arrives. Availability is reported in the same 2-bit
// saturating form as the core's pcie_rq_tag_av.
//
// Optional feature (compile-time macro PCIE_TAG_TIMEOUT_EN):
//   Per-tag 2-bit age driven by timeout_tick. Expired tags are reported one
//   per cycle on timeout_tag/timeout_valid and reclaimed on that same edge.
//   When the macro is undefined, timeout_tick is ignored and the timeout
//   outputs are tied to 0.
//
// Ports:
//   user_clk           clock
//   user_reset_n       synchronous active-low reset
//   m_tag              offered free tag (registered)
//   m_tag_valid        m_tag is valid (registered)
//   m_tag_ready        requester consumes m_tag this cycle
//   s_release_tag      tag whose final completion arrived
//   s_release_valid    release strobe
//   cfg_ext_tag_en     0: only tags 0..31 may be allocated
//   tag_av             free allocatable tags, saturating at 3 (registered)
//   outstanding_count  tags currently in use (registered)
//   release_err        one-cycle pulse: bad release (free or out of range)
//   timeout_tick       age timebase strobe (optional feature only)
//   timeout_tag        timed-out tag (optional feature only)
//   timeout_valid      one pulse per timed-out tag (optional feature only)
// ---------------------------------------------------------------------------
module pcie_us_rq_tag_mgr #(
    parameter int TAG_WIDTH = 6,
    parameter int TAG_COUNT = 64,
    parameter int CNT_WIDTH = $clog2(TAG_COUNT + 1)
) (
    input  logic                 user_clk,
    input  logic                 user_reset_n,
    output logic [TAG_WIDTH-1:0] m_tag,
    output logic                 m_tag_valid,
    input  logic                 m_tag_ready,
    input  logic [TAG_WIDTH-1:0] s_release_tag,
    input  logic                 s_release_valid,
    input  logic                 cfg_ext_tag_en,
    output logic [1:0]           tag_av,
    output logic [CNT_WIDTH-1:0] outstanding_count,
    output logic                 release_err,
    input  logic                 timeout_tick,
    output logic [TAG_WIDTH-1:0] timeout_tag,
    output logic                 timeout_valid
);

    // Saturate a free-tag count to the 2-bit tag_av encoding.
    function automatic logic [1:0] sat_av(input logic [CNT_WIDTH-1:0] n);
        return (n > CNT_WIDTH'(3)) ? 2'd3 : n[1:0];
    endfunction

    logic [TAG_COUNT-1:0] in_use_q, in_use_d;
    logic [TAG_WIDTH-1:0] m_tag_q, m_tag_d;
    logic                 m_tag_valid_q, m_tag_valid_d;
    logic [CNT_WIDTH-1:0] outstanding_q, outstanding_d;
    logic [1:0]           tag_av_q, tag_av_d;
    logic                 release_err_q, release_err_d;

    logic [TAG_COUNT-1:0] alloc_vec;    // one-hot of the tag taken this cycle
    logic [TAG_COUNT-1:0] rel_vec;      // one-hot of an in-range release
    logic [TAG_COUNT-1:0] rel_hit_vec;  // release that targets an in-use tag
    logic [TAG_COUNT-1:0] reclaim_vec;  // tag reclaimed by timeout
    logic                 sel_found;
    logic [TAG_WIDTH-1:0] sel_tag;
    logic                 hold;
    logic                 withdraw;

    // Decode handshake and release into one-hot vectors. Loop-based decode
    // keeps out-of-range release tags (>= TAG_COUNT) naturally unmatched.
    always_comb begin
        alloc_vec = '0;
        rel_vec   = '0;
        for (int i = 0; i < TAG_COUNT; i++) begin
            if (m_tag_valid_q && m_tag_ready && (m_tag_q == TAG_WIDTH'(i)))
                alloc_vec[i] = 1'b1;
            if (s_release_valid && (s_release_tag == TAG_WIDTH'(i)))
                rel_vec[i] = 1'b1;
        end
    end

    assign rel_hit_vec   = rel_vec & in_use_q;
    assign release_err_d = s_release_valid && (rel_hit_vec == '0);
    assign in_use_d      = (in_use_q | alloc_vec) & ~rel_hit_vec & ~reclaim_vec;

    // Lowest clear tag in the next-state bitmap, below the extended-tag limit.
    always_comb begin
        sel_found = 1'b0;
        sel_tag   = '0;
        for (int i = TAG_COUNT - 1; i >= 0; i--) begin
            if (!in_use_d[i] && (cfg_ext_tag_en || (i < 32))) begin
                sel_found = 1'b1;
                sel_tag   = TAG_WIDTH'(i);
            end
        end
    end

    // An unaccepted offer is held stable. If extended tags get disabled while
    // an offer >= 32 is pending, the offer is dropped for one cycle and then
    // recomputed under the new limit.
    assign hold     = m_tag_valid_q && !m_tag_ready;
    assign withdraw = hold && !cfg_ext_tag_en && (32'(m_tag_q) >= 32);

    always_comb begin
        m_tag_d       = sel_tag;
        m_tag_valid_d = sel_found;
        if (withdraw) begin
            m_tag_d       = m_tag_q;
            m_tag_valid_d = 1'b0;
        end else if (hold) begin
            m_tag_d       = m_tag_q;
            m_tag_valid_d = 1'b1;
        end
    end

    // Counts are taken from the current bitmap, so they trail it by a cycle.
    always_comb begin
        logic [CNT_WIDTH-1:0] used;
        logic [CNT_WIDTH-1:0] free_lim;
        used     = '0;
        free_lim = '0;
        for (int i = 0; i < TAG_COUNT; i++) begin
            used = used + CNT_WIDTH'(in_use_q[i]);
            if (!in_use_q[i] && (cfg_ext_tag_en || (i < 32)))
                free_lim = free_lim + CNT_WIDTH'(1);
        end
        outstanding_d = used;
        tag_av_d      = sat_av(free_lim);
    end

    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            in_use_q      <= '0;
            m_tag_q       <= '0;
            m_tag_valid_q <= 1'b0;
            outstanding_q <= '0;
            tag_av_q      <= 2'd0;
            release_err_q <= 1'b0;
        end else begin
            in_use_q      <= in_use_d;
            m_tag_q       <= m_tag_d;
            m_tag_valid_q <= m_tag_valid_d;
            outstanding_q <= outstanding_d;
            tag_av_q      <= tag_av_d;
            release_err_q <= release_err_d;
        end
    end

`ifdef PCIE_TAG_TIMEOUT_EN
    logic [1:0]           age_q [TAG_COUNT];
    logic [TAG_COUNT-1:0] expired_q;
    logic [TAG_COUNT-1:0] to_cand;
    logic [TAG_WIDTH-1:0] to_tag_q, to_tag_d;
    logic                 to_valid_q, to_valid_d;

    // A tag released in the same cycle is freed normally and not reported.
    always_comb begin
        to_cand     = expired_q & ~rel_hit_vec;
        to_valid_d  = 1'b0;
        to_tag_d    = '0;
        reclaim_vec = '0;
        for (int i = TAG_COUNT - 1; i >= 0; i--) begin
            if (to_cand[i]) begin
                to_valid_d = 1'b1;
                to_tag_d   = TAG_WIDTH'(i);
            end
        end
        for (int i = 0; i < TAG_COUNT; i++)
            reclaim_vec[i] = to_valid_d && (to_tag_d == TAG_WIDTH'(i));
    end

    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            for (int i = 0; i < TAG_COUNT; i++) age_q[i] <= 2'd0;
            expired_q  <= '0;
            to_tag_q   <= '0;
            to_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < TAG_COUNT; i++) begin
                if (alloc_vec[i])
                    age_q[i] <= 2'd0;
                else if (timeout_tick && in_use_q[i] && (age_q[i] != 2'd3))
                    age_q[i] <= age_q[i] + 2'd1;

                if (reclaim_vec[i] || rel_hit_vec[i])
                    expired_q[i] <= 1'b0;
                else if (timeout_tick && in_use_q[i] && (age_q[i] == 2'd3))
                    expired_q[i] <= 1'b1;
            end
            to_tag_q   <= to_tag_d;
            to_valid_q <= to_valid_d;
        end
    end

    assign timeout_tag   = to_tag_q;
    assign timeout_valid = to_valid_q;
`else
    logic unused_timeout_tick;

    assign unused_timeout_tick = timeout_tick;
    assign reclaim_vec         = '0;
    assign timeout_tag         = '0;
    assign timeout_valid       = 1'b0;
`endif

    assign m_tag             = m_tag_q;
    assign m_tag_valid       = m_tag_valid_q;
    assign outstanding_count = outstanding_q;
    assign tag_av            = tag_av_q;
    assign release_err       = release_err_q;

endmodule

// File: tb/tb_pcie_us_rq_tag_mgr.sv
// ---------------------------------------------------------------------------
// Self-checking bench for pcie_us_rq_tag_mgr (default parameters).
// Expected tag offers are pushed to a queue before the requester starts
// consuming and are popped as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_pcie_us_rq_tag_mgr;
    localparam int TW = 6;
    localparam int TC = 64;
    localparam int CW = $clog2(TC + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [TW-1:0] m_tag;
    logic          m_tag_valid;
    logic          m_tag_ready;
    logic [TW-1:0] rel_tag;
    logic          rel_v;
    logic          ext_en;
    logic [1:0]    tag_av;
    logic [CW-1:0] outstanding_count;
    logic          release_err;
    logic          tick;
    logic [TW-1:0] timeout_tag;
    logic          timeout_valid;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    pcie_us_rq_tag_mgr #(.TAG_WIDTH(TW), .TAG_COUNT(TC)) dut (
        .user_clk          (clk),
        .user_reset_n      (rst_n),
        .m_tag             (m_tag),
        .m_tag_valid       (m_tag_valid),
        .m_tag_ready       (m_tag_ready),
        .s_release_tag     (rel_tag),
        .s_release_valid   (rel_v),
        .cfg_ext_tag_en    (ext_en),
        .tag_av            (tag_av),
        .outstanding_count (outstanding_count),
        .release_err       (release_err),
        .timeout_tick      (tick),
        .timeout_tag       (timeout_tag),
        .timeout_valid     (timeout_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ext);
        rst_n = 1'b0; m_tag_ready = 1'b0; rel_v = 1'b0; rel_tag = '0;
        tick = 1'b0; ext_en = ext;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m_tag_ready = 1'b0; rel_v = 1'b0; rel_tag = '0;
        tick = 1'b0; ext_en = 1'b1;
        step(); step();
        n_vec++; if (m_tag_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", m_tag_valid); end
        n_vec++; if (m_tag !== '0) begin n_err++; $display("FAIL rst_tag: got %0d want 0", m_tag); end
        n_vec++; if (tag_av !== 2'd0) begin n_err++; $display("FAIL rst_tag_av: got %0d want 0", tag_av); end
        n_vec++; if (outstanding_count !== '0) begin n_err++; $display("FAIL rst_outstanding: got %0d want 0", outstanding_count); end
        n_vec++; if (release_err !== 1'b0) begin n_err++; $display("FAIL rst_release_err: got %b want 0", release_err); end
        n_vec++; if (timeout_valid !== 1'b0 || timeout_tag !== '0) begin n_err++; $display("FAIL rst_timeout: got %b/%0d want 0/0", timeout_valid, timeout_tag); end
        rst_n = 1'b1;
        step();
        n_vec++; if (m_tag_valid !== 1'b1 || m_tag !== '0) begin n_err++; $display("FAIL first_offer: got %b/%0d want 1/0", m_tag_valid, m_tag); end
        n_vec++; if (tag_av !== 2'd3) begin n_err++; $display("FAIL first_tag_av: got %0d want 3", tag_av); end
    endtask

    // Back-to-back allocation of every tag, one per cycle.
    task automatic test_back_to_back();
        int e;
        for (int t = 0; t < TC; t++) exp_q.push_back(t);
        m_tag_ready = 1'b1;
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            n_vec++;
            if (m_tag_valid === 1'b1) begin
                e = exp_q.pop_front();
                if (m_tag !== TW'(e)) begin n_err++; $display("FAIL b2b_tag: got %0d want %0d", m_tag, e); end
            end else begin
                n_err++; $display("FAIL b2b_gap: m_tag_valid=%b want 1 at cycle %0d", m_tag_valid, c);
            end
            step();
        end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_budget: %0d tags not offered want 0", exp_q.size()); exp_q.delete(); end
        m_tag_ready = 1'b0;
        n_vec++; if (m_tag_valid !== 1'b0) begin n_err++; $display("FAIL full_valid: got %b want 0", m_tag_valid); end
        step();
        n_vec++; if (outstanding_count !== CW'(64)) begin n_err++; $display("FAIL full_outstanding: got %0d want 64", outstanding_count); end
        n_vec++; if (tag_av !== 2'd0) begin n_err++; $display("FAIL full_tag_av: got %0d want 0", tag_av); end
    endtask

    task automatic test_release_reoffer();
        int e;
        rel_tag = TW'(17); rel_v = 1'b1;
        step();
        rel_v = 1'b0;
        n_vec++; if (m_tag_valid !== 1'b1 || m_tag !== TW'(17)) begin n_err++; $display("FAIL reoffer: got %b/%0d want 1/17", m_tag_valid, m_tag); end
        n_vec++; if (release_err !== 1'b0) begin n_err++; $display("FAIL reoffer_err: got %b want 0", release_err); end
        step();
        n_vec++; if (tag_av !== 2'd1) begin n_err++; $display("FAIL reoffer_tag_av: got %0d want 1", tag_av); end
        n_vec++; if (outstanding_count !== CW'(63)) begin n_err++; $display("FAIL reoffer_outstanding: got %0d want 63", outstanding_count); end
        exp_q.push_back(17);
        m_tag_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (m_tag_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_vec++; if (m_tag !== TW'(e)) begin n_err++; $display("FAIL reoffer_take: got %0d want %0d", m_tag, e); end
            end
            step();
        end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL reoffer_budget: %0d left want 0", exp_q.size()); exp_q.delete(); end
        m_tag_ready = 1'b0;
    endtask

    task automatic test_limit32();
        int e;
        do_reset(1'b0);
        for (int t = 0; t < 32; t++) exp_q.push_back(t);
        m_tag_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            if (m_tag_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_vec++; if (m_tag !== TW'(e)) begin n_err++; $display("FAIL lim_tag: got %0d want %0d", m_tag, e); end
            end
            step();
        end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL lim_budget: %0d left want 0", exp_q.size()); exp_q.delete(); end
        n_vec++; if (m_tag_valid !== 1'b0) begin n_err++; $display("FAIL lim_valid: got %b want 0", m_tag_valid); end
        step();
        n_vec++; if (m_tag_valid !== 1'b0) begin n_err++; $display("FAIL lim_valid2: got %b want 0", m_tag_valid); end
        n_vec++; if (outstanding_count !== CW'(32)) begin n_err++; $display("FAIL lim_outstanding: got %0d want 32", outstanding_count); end
        n_vec++; if (tag_av !== 2'd0) begin n_err++; $display("FAIL lim_tag_av: got %0d want 0", tag_av); end
        m_tag_ready = 1'b0;
    endtask

    // Follows test_limit32: tags 0..31 in use, extended tags disabled.
    task automatic test_release_err();
        rel_tag = TW'(5); rel_v = 1'b1;
        step();
        n_vec++; if (release_err !== 1'b0) begin n_err++; $display("FAIL rel_good_err: got %b want 0", release_err); end
        step();
        rel_v = 1'b0;
        n_vec++; if (release_err !== 1'b1) begin n_err++; $display("FAIL rel_free_err: got %b want 1", release_err); end
        n_vec++; if (outstanding_count !== CW'(31)) begin n_err++; $display("FAIL rel_free_cnt: got %0d want 31", outstanding_count); end
        step();
        n_vec++; if (release_err !== 1'b0) begin n_err++; $display("FAIL rel_err_pulse: got %b want 0", release_err); end
        n_vec++; if (outstanding_count !== CW'(31)) begin n_err++; $display("FAIL rel_err_cnt: got %0d want 31", outstanding_count); end
        n_vec++; if (m_tag_valid !== 1'b1 || m_tag !== TW'(5)) begin n_err++; $display("FAIL rel_err_offer: got %b/%0d want 1/5", m_tag_valid, m_tag); end
    endtask

    task automatic test_ext_drop();
        int e;
        do_reset(1'b1);
        for (int t = 0; t <= 32; t++) exp_q.push_back(t);
        m_tag_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            if (m_tag_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_vec++; if (m_tag !== TW'(e)) begin n_err++; $display("FAIL ext_tag: got %0d want %0d", m_tag, e); end
            end
            step();
        end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL ext_budget: %0d left want 0", exp_q.size()); exp_q.delete(); end
        m_tag_ready = 1'b0;
        n_vec++; if (m_tag_valid !== 1'b1 || m_tag !== TW'(33)) begin n_err++; $display("FAIL ext_held: got %b/%0d want 1/33", m_tag_valid, m_tag); end
        ext_en = 1'b0;
        step();
        n_vec++; if (m_tag_valid !== 1'b0) begin n_err++; $display("FAIL ext_withdraw: got %b want 0", m_tag_valid); end
        step();
        n_vec++; if (m_tag_valid !== 1'b0) begin n_err++; $display("FAIL ext_none: got %b want 0", m_tag_valid); end
        rel_tag = TW'(32); rel_v = 1'b1;
        step();
        rel_v = 1'b0;
        n_vec++; if (release_err !== 1'b0) begin n_err++; $display("FAIL ext_rel_high: got %b want 0", release_err); end
        step();
        n_vec++; if (outstanding_count !== CW'(32)) begin n_err++; $display("FAIL ext_cnt: got %0d want 32", outstanding_count); end
        n_vec++; if (tag_av !== 2'd0) begin n_err++; $display("FAIL ext_tag_av: got %0d want 0", tag_av); end
        ext_en = 1'b1;
        step();
        n_vec++; if (m_tag_valid !== 1'b1 || m_tag !== TW'(32)) begin n_err++; $display("FAIL ext_reen: got %b/%0d want 1/32", m_tag_valid, m_tag); end
    endtask

    task automatic test_simultaneous();
        int e;
        do_reset(1'b1);
        for (int t = 0; t < 3; t++) exp_q.push_back(t);
        m_tag_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (m_tag_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_vec++; if (m_tag !== TW'(e)) begin n_err++; $display("FAIL sim_tag: got %0d want %0d", m_tag, e); end
            end
            step();
        end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL sim_budget: %0d left want 0", exp_q.size()); exp_q.delete(); end
        m_tag_ready = 1'b0;
        step();
        n_vec++; if (outstanding_count !== CW'(3) || m_tag !== TW'(3)) begin n_err++; $display("FAIL sim_pre: got cnt %0d tag %0d want 3/3", outstanding_count, m_tag); end
        m_tag_ready = 1'b1; rel_tag = TW'(1); rel_v = 1'b1;
        step();
        m_tag_ready = 1'b0; rel_v = 1'b0;
        n_vec++; if (m_tag_valid !== 1'b1 || m_tag !== TW'(1)) begin n_err++; $display("FAIL sim_offer: got %b/%0d want 1/1", m_tag_valid, m_tag); end
        n_vec++; if (release_err !== 1'b0) begin n_err++; $display("FAIL sim_err: got %b want 0", release_err); end
        step();
        n_vec++; if (outstanding_count !== CW'(3)) begin n_err++; $display("FAIL sim_cnt: got %0d want 3", outstanding_count); end
    endtask

    // Follows test_simultaneous: tags 0,2,3 in use.
    task automatic test_mid_reset();
        rst_n = 1'b0; rel_tag = TW'(2); rel_v = 1'b1;
        step();
        n_vec++; if (release_err !== 1'b0 || m_tag_valid !== 1'b0) begin n_err++; $display("FAIL mrst_out: got err %b valid %b want 0/0", release_err, m_tag_valid); end
        n_vec++; if (outstanding_count !== '0) begin n_err++; $display("FAIL mrst_cnt: got %0d want 0", outstanding_count); end
        rst_n = 1'b1;
        step();
        rel_v = 1'b0;
        n_vec++; if (release_err !== 1'b1) begin n_err++; $display("FAIL mrst_err: got %b want 1", release_err); end
        n_vec++; if (m_tag_valid !== 1'b1 || m_tag !== '0) begin n_err++; $display("FAIL mrst_offer: got %b/%0d want 1/0", m_tag_valid, m_tag); end
        step();
        n_vec++; if (outstanding_count !== '0) begin n_err++; $display("FAIL mrst_cnt2: got %0d want 0", outstanding_count); end
    endtask

    task automatic test_timeout();
        int e;
        do_reset(1'b1);
        exp_q.push_back(0); exp_q.push_back(1);
        m_tag_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (m_tag_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_vec++; if (m_tag !== TW'(e)) begin n_err++; $display("FAIL to_alloc: got %0d want %0d", m_tag, e); end
            end
            step();
        end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL to_budget: %0d left want 0", exp_q.size()); exp_q.delete(); end
        m_tag_ready = 1'b0;
        tick = 1'b1;
        for (int k = 0; k < 4; k++) step();
        tick = 1'b0;
`ifdef PCIE_TAG_TIMEOUT_EN
        step();
        n_vec++; if (timeout_valid !== 1'b1 || timeout_tag !== TW'(0)) begin n_err++; $display("FAIL to_first: got %b/%0d want 1/0", timeout_valid, timeout_tag); end
        step();
        n_vec++; if (timeout_valid !== 1'b1 || timeout_tag !== TW'(1)) begin n_err++; $display("FAIL to_second: got %b/%0d want 1/1", timeout_valid, timeout_tag); end
        step();
        n_vec++; if (timeout_valid !== 1'b0) begin n_err++; $display("FAIL to_done: got %b want 0", timeout_valid); end
        n_vec++; if (outstanding_count !== '0) begin n_err++; $display("FAIL to_cnt: got %0d want 0", outstanding_count); end
        rel_tag = TW'(0); rel_v = 1'b1;
        step();
        rel_v = 1'b0;
        n_vec++; if (release_err !== 1'b1) begin n_err++; $display("FAIL to_rel_err: got %b want 1", release_err); end
`else
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++; if (timeout_valid !== 1'b0 || timeout_tag !== '0) begin n_err++; $display("FAIL to_off: got %b/%0d want 0/0", timeout_valid, timeout_tag); end
        end
        n_vec++; if (outstanding_count !== CW'(2)) begin n_err++; $display("FAIL to_off_cnt: got %0d want 2", outstanding_count); end
        rel_tag = TW'(0); rel_v = 1'b1;
        step();
        rel_v = 1'b0;
        n_vec++; if (release_err !== 1'b0) begin n_err++; $display("FAIL to_off_rel: got %b want 0", release_err); end
`endif
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_release_reoffer();
        test_limit32();
        test_release_err();
        test_ext_drop();
        test_simultaneous();
        test_mid_reset();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
